// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running h/v counters, registered active-area
// coordinates, and hsync/vsync/de retimed by PIPE_DLY clocks to match the pixel path.
module vga_timing_gen #(
   parameter int WIDTH    = 10,
   parameter int CNT_W    = 11,
   parameter int H_ACTIVE = 1024,
   parameter int H_FP     = 24,
   parameter int H_SYNC   = 136,
   parameter int H_BP     = 160,
   parameter int V_ACTIVE = 768,
   parameter int V_FP     = 3,
   parameter int V_SYNC   = 6,
   parameter int V_BP     = 29,
   parameter bit SYNC_POL = 1'b0,
   parameter int PIPE_DLY = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [WIDTH-1:0] line_coo,
   output logic [WIDTH-1:0] ver_coo,
   output logic             coo_valid,
   output logic             frame_start,
   output logic             hsync,
   output logic             vsync,
   output logic             de
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic             SYNC_OFF = ~SYNC_POL;

   logic [CNT_W-1:0] h_cnt, v_cnt;
   logic [CNT_W-1:0] h_next, v_next;
   logic             valid_next, hs_act, vs_act;
   logic             hs_s0, vs_s0;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      h_next = h_cnt + CNT_W'(1);
      v_next = v_cnt;
      if (h_cnt == H_LAST) begin
         h_next = '0;
         v_next = (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
      end
   end

   // vs_act depends only on v_cnt, so vsync can only move at a line boundary.
   assign valid_next = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
   assign hs_act     = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
   assign vs_act     = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

   // NOTE: sequential state uses non-blocking assignments so all flops sample together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         h_cnt <= h_next;
         v_cnt <= v_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_coo    <= '0;
         ver_coo     <= '0;
         coo_valid   <= 1'b0;
         frame_start <= 1'b0;
         hs_s0       <= SYNC_OFF;
         vs_s0       <= SYNC_OFF;
      end else begin
         line_coo    <= valid_next ? h_cnt[WIDTH-1:0] : '0;
         ver_coo     <= valid_next ? v_cnt[WIDTH-1:0] : '0;
         coo_valid   <= valid_next;
         frame_start <= (h_cnt == '0) && (v_cnt == '0);
         hs_s0       <= hs_act ? SYNC_POL : SYNC_OFF;
         vs_s0       <= vs_act ? SYNC_POL : SYNC_OFF;
      end
   end

   if (PIPE_DLY == 0) begin : g_no_dly
      assign hsync = hs_s0;
      assign vsync = vs_s0;
      assign de    = coo_valid;
   end else begin : g_dly
      logic [PIPE_DLY-1:0] hs_pipe, vs_pipe, de_pipe;

      // NOTE: the delay line is reset to the inactive level so no sync pulse leaks out of reset.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            hs_pipe <= {PIPE_DLY{SYNC_OFF}};
            vs_pipe <= {PIPE_DLY{SYNC_OFF}};
            de_pipe <= '0;
         end else begin
            hs_pipe[0] <= hs_s0;
            vs_pipe[0] <= vs_s0;
            de_pipe[0] <= coo_valid;
            for (int i = 1; i < PIPE_DLY; i++) begin
               hs_pipe[i] <= hs_pipe[i-1];
               vs_pipe[i] <= vs_pipe[i-1];
               de_pipe[i] <= de_pipe[i-1];
            end
         end
      end

      assign hsync = hs_pipe[PIPE_DLY-1];
      assign vsync = vs_pipe[PIPE_DLY-1];
      assign de    = de_pipe[PIPE_DLY-1];
   end

endmodule
